// File: rtl/prng_pkg.sv
// Shared constants and the Galois LFSR step function for the pseudo-random source.
package prng_pkg;

    localparam int               LFSR_W      = 16;
    localparam logic [LFSR_W-1:0] DEF_SEED    = 16'hACE1;
    localparam logic [LFSR_W-1:0] DEF_TAPS    = 16'hB400;
    // Last step_count value before the period closes (65535 steps total).
    localparam logic [LFSR_W-1:0] PERIOD_LAST = 16'hFFFE;

    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] state,
                                                     input logic [LFSR_W-1:0] taps);
        return state[0] ? ((state >> 1) ^ taps) : (state >> 1);
    endfunction

endpackage

// File: rtl/lfsr16_core.sv
// 16-bit Galois LFSR register with a priority seed load and step enable.
module lfsr16_core
    import prng_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = DEF_SEED,
    parameter logic [LFSR_W-1:0] TAPS = DEF_TAPS
) (
    input  logic              CLK,
    input  logic              n_RESET,
    input  logic              en,
    input  logic              load,
    input  logic [LFSR_W-1:0] load_val,
    output logic [LFSR_W-1:0] state
);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, regardless of block ordering.
    always_ff @(posedge CLK or negedge n_RESET) begin
        if (!n_RESET) begin
            state <= SEED;
        end else if (load) begin
            state <= load_val;
        end else if (en) begin
            state <= lfsr_next(state, TAPS);
        end
    end

endmodule

// File: rtl/prng_share_ctrl.sv
// Round-robin arbiter sharing one LFSR among NREQ requesters, with seed
// loading, zero-seed rejection and period-wrap flagging.
module prng_share_ctrl
    import prng_pkg::*;
#(
    parameter int                NREQ = 4,
    parameter logic [LFSR_W-1:0] SEED = DEF_SEED,
    parameter logic [LFSR_W-1:0] TAPS = DEF_TAPS
) (
    input  logic              CLK,
    input  logic              n_RESET,
    input  logic [NREQ-1:0]   req,
    input  logic              seed_load,
    input  logic [LFSR_W-1:0] seed_in,
    output logic [NREQ-1:0]   gnt,
    output logic              rnd_valid,
    output logic [LFSR_W-1:0] rnd_data,
    output logic              seed_err,
    output logic              wrap,
    output logic [LFSR_W-1:0] step_count
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0]     rr_ptr;
    logic [PW-1:0]     winner;
    logic [PW-1:0]     cand_idx;
    logic              found;
    logic              load_ok;
    logic              step_en;
    logic [LFSR_W-1:0] state;

    assign load_ok = seed_load && (seed_in != '0);
    assign step_en = !seed_load && (|req);

    lfsr16_core #(
        .SEED (SEED),
        .TAPS (TAPS)
    ) u_core (
        .CLK      (CLK),
        .n_RESET  (n_RESET),
        .en       (step_en),
        .load     (load_ok),
        .load_val (seed_in),
        .state    (state)
    );

    // Search starts just after the last winner, so the last winner has lowest priority.
    // NOTE: every variable gets a default before the loop so no latch is inferred.
    always_comb begin
        winner   = rr_ptr;
        cand_idx = '0;
        found    = 1'b0;
        for (int i = 1; i <= NREQ; i++) begin
            cand_idx = PW'((int'(rr_ptr) + i) % NREQ);
            if (!found && req[cand_idx]) begin
                winner = cand_idx;
                found  = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge n_RESET) begin
        if (!n_RESET) begin
            gnt        <= '0;
            rnd_valid  <= 1'b0;
            rnd_data   <= '0;
            seed_err   <= 1'b0;
            wrap       <= 1'b0;
            step_count <= '0;
            rr_ptr     <= PW'(NREQ - 1);
        end else begin
            seed_err <= 1'b0;
            wrap     <= 1'b0;
            if (seed_load) begin
                // Requests in a load cycle are dropped, not queued.
                gnt       <= '0;
                rnd_valid <= 1'b0;
                if (seed_in != '0) begin
                    step_count <= '0;
                end else begin
                    seed_err <= 1'b1;
                end
            end else if (|req) begin
                gnt        <= NREQ'(1) << winner;
                rnd_valid  <= 1'b1;
                rnd_data   <= state;
                rr_ptr     <= winner;
                wrap       <= (step_count == PERIOD_LAST);
                step_count <= (step_count == PERIOD_LAST) ? '0 : step_count + 1'b1;
            end else begin
                gnt       <= '0;
                rnd_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_prng_share_ctrl.sv
// Scoreboard bench for prng_share_ctrl: stimulus pushes expected outputs,
// a negedge monitor pops and compares whenever the DUT presents a result.
module tb_prng_share_ctrl;

    localparam int NREQ = 4;

    logic            CLK = 1'b0;
    logic            n_RESET = 1'b0;
    logic [NREQ-1:0] req = '0;
    logic            seed_load = 1'b0;
    logic [15:0]     seed_in = '0;
    logic [NREQ-1:0] gnt;
    logic            rnd_valid;
    logic [15:0]     rnd_data;
    logic            seed_err;
    logic            wrap;
    logic [15:0]     step_count;

    prng_share_ctrl #(
        .NREQ (NREQ),
        .SEED (16'hACE1),
        .TAPS (16'hB400)
    ) dut (
        .CLK        (CLK),
        .n_RESET    (n_RESET),
        .req        (req),
        .seed_load  (seed_load),
        .seed_in    (seed_in),
        .gnt        (gnt),
        .rnd_valid  (rnd_valid),
        .rnd_data   (rnd_data),
        .seed_err   (seed_err),
        .wrap       (wrap),
        .step_count (step_count)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [NREQ-1:0] gnt;
        logic [15:0]     data;
        logic            wrap;
        logic            err;
        logic [15:0]     step;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [NREQ-1:0] g, input logic [15:0] d,
                        input logic w, input logic e, input logic [15:0] s);
        exp_t x;
        x.gnt  = g;
        x.data = d;
        x.wrap = w;
        x.err  = e;
        x.step = s;
        sb.push_back(x);
    endtask

    // Drive one cycle of inputs; returns 1 time unit after the sampling edge.
    task automatic drive(input logic [NREQ-1:0] r, input logic sl, input logic [15:0] si);
        req       = r;
        seed_load = sl;
        seed_in   = si;
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        req       = '0;
        seed_load = 1'b0;
        n_RESET   = 1'b0;
        @(posedge CLK);
        #1;
        n_RESET = 1'b1;
    endtask

    task automatic drain();
        for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge CLK);
        #1;
        check("scoreboard_drained", sb.size(), 0);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_gnt"}, gnt, 0);
        check({tag, "_rnd_valid"}, rnd_valid, 0);
        check({tag, "_rnd_data"}, rnd_data, 0);
        check({tag, "_seed_err"}, seed_err, 0);
        check({tag, "_wrap"}, wrap, 0);
        check({tag, "_step_count"}, step_count, 0);
    endtask

    // Monitor: any presented result must match the oldest expectation.
    always @(negedge CLK) begin
        if (n_RESET && (rnd_valid || seed_err)) begin
            if (sb.size() == 0) begin
                check("unexpected_output", {gnt, seed_err}, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("gnt", gnt, e.gnt);
                check("rnd_valid", rnd_valid, (e.gnt != 0));
                if (e.gnt != 0) check("rnd_data", rnd_data, e.data);
                check("wrap", wrap, e.wrap);
                check("seed_err", seed_err, e.err);
                check("step_count", step_count, e.step);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] s;
        logic [15:0] nxt;

        // Reset values, both in reset and right after release.
        #2;
        check_idle_outputs("in_reset");
        do_reset();
        check_idle_outputs("post_reset");

        // Lone requester 0 gets every cycle.
        push(4'b0001, 16'hACE1, 0, 0, 16'd1);
        push(4'b0001, 16'hE270, 0, 0, 16'd2);
        push(4'b0001, 16'h7138, 0, 0, 16'd3);
        push(4'b0001, 16'h389C, 0, 0, 16'd4);
        repeat (4) drive(4'b0001, 1'b0, 16'h0);
        drive(4'b0000, 1'b0, 16'h0);
        drain();

        // Full contention rotates 0,1,2,3,0.
        do_reset();
        check("reset_clears_rnd_data", rnd_data, 0);
        push(4'b0001, 16'hACE1, 0, 0, 16'd1);
        push(4'b0010, 16'hE270, 0, 0, 16'd2);
        push(4'b0100, 16'h7138, 0, 0, 16'd3);
        push(4'b1000, 16'h389C, 0, 0, 16'd4);
        push(4'b0001, 16'h1C4E, 0, 0, 16'd5);
        repeat (5) drive(4'b1111, 1'b0, 16'h0);

        // Zero seed rejected; request dropped; sequence continues.
        push(4'b0000, 16'h0000, 0, 1, 16'd5);
        drive(4'b0001, 1'b1, 16'h0000);
        push(4'b0001, 16'h0E27, 0, 0, 16'd6);
        drive(4'b0001, 1'b0, 16'h0);
        drive(4'b0000, 1'b0, 16'h0);
        drain();

        // Seed load of 0001 with a dropped request, then two grants.
        drive(4'b0001, 1'b1, 16'h0001);
        check("load_step_count_zero", step_count, 0);
        check("load_no_grant", gnt, 0);
        push(4'b0001, 16'h0001, 0, 0, 16'd1);
        push(4'b0001, 16'hB400, 0, 0, 16'd2);
        repeat (2) drive(4'b0001, 1'b0, 16'h0);

        // Mid-stream asynchronous reset under full contention.
        push(4'b0010, 16'h5A00, 0, 0, 16'd3);
        push(4'b0100, 16'h2D00, 0, 0, 16'd4);
        repeat (2) drive(4'b1111, 1'b0, 16'h0);
        @(negedge CLK);
        #1;
        n_RESET = 1'b0;
        #1;
        check_idle_outputs("async_reset");
        @(posedge CLK);
        #1;
        n_RESET = 1'b1;
        push(4'b0001, 16'hACE1, 0, 0, 16'd1);
        push(4'b0010, 16'hE270, 0, 0, 16'd2);
        repeat (2) drive(4'b1111, 1'b0, 16'h0);
        drive(4'b0000, 1'b0, 16'h0);
        drain();

        // Full period: wrap on grant 65535, grant 65536 replays the seed.
        do_reset();
        s = 16'hACE1;
        for (int k = 1; k <= 65536; k++) begin
            if (k == 65536) push(4'b0001, 16'hACE1, 0, 0, 16'd1);
            else            push(4'b0001, s, (k == 65535), 0, 16'(k % 65535));
            nxt = {1'b0, s[15:1]} ^ (s[0] ? 16'hB400 : 16'h0000);
            s   = nxt;
            drive(4'b0001, 1'b0, 16'h0);
        end
        drive(4'b0000, 1'b0, 16'h0);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/prng_share_ctrl.md
# prng_share_ctrl

Sequencer and arbiter for the shared 16-bit Galois LFSR pseudo-random source. Up to NREQ requesters share one generator. The block grants one requester per cycle in round-robin order and returns the current word to that requester. It advances the LFSR only on a grant, supports run-time seed loading with zero-seed protection, and flags completion of each full 65535-step period.

## Interface
- NREQ, 4: number of requesters (2..8)
- SEED, 16'hACE1: LFSR state after reset
- TAPS, 16'hB400: Galois feedback mask (x^16+x^14+x^13+x^11+1)

- CLK  in  1  clock; all state updates on rising edge
- n_RESET  in  1  reset; one clock; reset is asynchronous and active-low
- req  in  NREQ  per-requester request level, sampled every rising edge
- seed_load  in  1  load seed_in into the LFSR this edge
- seed_in  in  16  new seed value
- gnt  out  NREQ  registered one-hot grant, valid the cycle after sampling
- rnd_valid  out  1  high whenever gnt is non-zero
- rnd_data  out  16  LFSR word handed to the granted requester
- seed_err  out  1  one-cycle pulse: seed_load was attempted with seed_in == 0
- wrap  out  1  one-cycle pulse, coincident with the grant that completes a full period
- step_count  out  16  number of LFSR steps since the last reset or seed load

## Operation
- Internal state S (16 b) and rr_ptr (index of the last granted requester).
- LFSR step: next(S) = S[0] ? (S >> 1) ^ TAPS : S >> 1. Sequence from 16'hACE1: ACE1, E270, 7138, 389C, …; period 65535; S never reaches 0.
- Per-edge priority order, highest first:
  - seed_load, seed_in != 0: S <= seed_in, step_count <= 0, gnt <= 0, rr_ptr held. Any req in this cycle is dropped, not queued.
  - seed_load, seed_in == 0: seed_err <= 1, S unchanged, gnt <= 0, req dropped.
  - |req: winner = first set bit searching rr_ptr+1, rr_ptr+2, … modulo NREQ. Then:
    - gnt <= onehot(winner), rnd_data <= S (pre-step value), rnd_valid <= 1
    - S <= next(S), rr_ptr <= winner
    - step_count <= step_count+1, wrapping 65534 -> 0
  - Otherwise: gnt <= 0, rnd_valid <= 0, and rnd_data, S and step_count hold.
- wrap <= 1 on the grant whose step returns step_count to 0, i.e. the 65535th grant after reset or seed load. The next grant then delivers the seed value again.
- A requester holding req continuously while all NREQ requesters contend receives exactly one grant every NREQ cycles.
- A lone requester holding req receives a grant every cycle.

## Timing
- Reset values:
  - gnt = 0, rnd_valid = 0, rnd_data = 0
  - seed_err = 0, wrap = 0, step_count = 0
  - S = SEED, rr_ptr = NREQ-1, so requester 0 has first priority
- Latency is 1 cycle: req sampled at edge k produces gnt, rnd_data, rnd_valid and wrap visible after edge k, for one cycle.
- gnt is never multi-hot. rnd_data is meaningful only while rnd_valid is high.
- seed_err and wrap last one cycle; they are not sticky.
- Reset asserted mid-operation clears all outputs and returns S to SEED immediately (asynchronous). It does not wait for a clock edge.
- A loaded seed takes effect on the first grant after the load edge.

## Structure
- Package prng_pkg holds:
  - LFSR_W = 16, DEF_SEED = 16'hACE1, DEF_TAPS = 16'hB400
  - function lfsr_next(state, taps)
- Sub-module lfsr16_core holds S, with inputs en and load/load_val, and output state. Its reset value comes from parameter SEED.
- Arbitration, step_count and flag generation live in prng_share_ctrl.

## Test plan
- Reset release, req=0001 held for 4 cycles -> gnt=0001 each cycle; rnd_data = ACE1, E270, 7138, 389C.
- Reset, req=1111 held -> gnt = 0001, 0010, 0100, 1000, 0001; rnd_data = ACE1, E270, 7138, 389C, then next(389C).
- seed_load with seed_in=0000 while req=0001 -> seed_err pulse, gnt=0 that cycle. Next grant returns the unchanged sequence value.
- seed_load with seed_in=0001, then req=0001 -> rnd_data = 0001, then B400; step_count = 1, then 2.
- req=0001 held for 65536 cycles after reset -> wrap pulses with grant #65535 (step_count -> 0). Grant #65536 has rnd_data = ACE1.
- n_RESET pulsed low mid-stream during req=1111 -> outputs 0 immediately. After release, the first grant is to requester 0 with rnd_data=ACE1.
